// File: rtl/echo_delay_reader.sv
// Echo delay controller: drains and primes an external delay FIFO, then mixes delayed samples into live audio.
// Build option ECHO_FEEDBACK_EN: RUN writes the mixed output back to the FIFO (decaying repeated echo).
//
// state | meaning
// IDLE  | disabled, no strobes, error flags held
// FLUSH | draining stale FIFO words, live audio passed straight through
// FILL  | priming the FIFO with delay_num dry samples
// RUN   | read delayed word, mix with registered live sample, write new word
module echo_delay_reader #(
    parameter int DW = 16,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] delay_num,
    input  logic [5:0]    gain,
    input  logic          sample_valid,
    input  logic [DW-1:0] audio_in,
    output logic          fifo_wr_en,
    output logic [31:0]   fifo_data,
    output logic          fifo_rd_en,
    input  logic [31:0]   fifo_q,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    output logic [DW-1:0] audio_out,
    output logic          out_valid,
    output logic          underrun,
    output logic          overrun,
    output logic          collision
);

    typedef enum logic [1:0] {IDLE, FLUSH, FILL, RUN} state_t;

    localparam int PW = DW + 8;
    localparam logic signed [PW-1:0] SAT_MAX = {{9{1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{9{1'b1}}, {(DW-1){1'b0}}};

    state_t        state;
    logic [CW-1:0] occ;
    logic [CW-1:0] occ_next;
    logic [CW-1:0] delay_lat;
    logic          flush_arm;
    logic          rd_run;
    logic          p1, p2, p3;
    logic          skip1, skip2;
    logic [DW-1:0] live_q;
    logic [5:0]    gain_q;
    logic [DW-1:0] mixed;
    logic signed [PW-1:0] dly_ext;
    logic signed [PW-1:0] live_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] sum;
    logic          unused_q_hi;

    assign unused_q_hi = ^fifo_q[31:DW];
    assign occ_next    = occ + CW'(1);

    // Flush reads follow fifo_empty combinationally so the drain never over-reads;
    // the arm flag keeps the first FLUSH cycle strobe-free.
    assign fifo_rd_en = rd_run | ((state == FLUSH) && flush_arm && !fifo_empty);

    always_comb begin
        dly_ext  = '0;
        if (!skip2)
            dly_ext = {{(PW-DW){fifo_q[DW-1]}}, fifo_q[DW-1:0]};
        live_ext = {{(PW-DW){live_q[DW-1]}}, live_q};
        prod     = dly_ext * $signed({{(PW-6){1'b0}}, gain_q});
        sum      = (prod >>> 6) + live_ext;
        if (sum > SAT_MAX)
            mixed = SAT_MAX[DW-1:0];
        else if (sum < SAT_MIN)
            mixed = SAT_MIN[DW-1:0];
        else
            mixed = sum[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            occ        <= '0;
            delay_lat  <= CW'(1);
            flush_arm  <= 1'b0;
            rd_run     <= 1'b0;
            p1         <= 1'b0;
            p2         <= 1'b0;
            p3         <= 1'b0;
            skip1      <= 1'b0;
            skip2      <= 1'b0;
            live_q     <= '0;
            gain_q     <= '0;
            fifo_wr_en <= 1'b0;
            fifo_data  <= '0;
            audio_out  <= '0;
            out_valid  <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
            collision  <= 1'b0;
        end else begin
            fifo_wr_en <= 1'b0;
            out_valid  <= 1'b0;
            rd_run     <= 1'b0;
            flush_arm  <= (state == FLUSH);
            p1         <= 1'b0;
            p2         <= p1;
            p3         <= p2;
            skip2      <= skip1;
            if (!en) begin
                state     <= IDLE;
                flush_arm <= 1'b0;
                p2        <= 1'b0;
                p3        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= FLUSH;
                        underrun  <= 1'b0;
                        overrun   <= 1'b0;
                        collision <= 1'b0;
                    end
                    FLUSH: begin
                        if (sample_valid) begin
                            audio_out <= audio_in;
                            out_valid <= 1'b1;
                        end
                        if (fifo_empty) begin
                            state     <= FILL;
                            occ       <= '0;
                            delay_lat <= (delay_num == '0) ? CW'(1) : delay_num;
                        end
                    end
                    FILL: begin
                        if (sample_valid) begin
                            audio_out <= audio_in;
                            out_valid <= 1'b1;
                            if (fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                fifo_wr_en <= 1'b1;
                                fifo_data  <= 32'(audio_in);
                                occ        <= occ_next;
                                if (occ_next == delay_lat)
                                    state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (sample_valid) begin
                            if (p1 || p2 || p3) begin
                                collision <= 1'b1;
                            end else begin
                                live_q <= audio_in;
                                gain_q <= gain;
                                p1     <= 1'b1;
                                skip1  <= fifo_empty;
                                if (fifo_empty)
                                    underrun <= 1'b1;
                                else
                                    rd_run <= 1'b1;
`ifndef ECHO_FEEDBACK_EN
                                if (fifo_full) begin
                                    overrun <= 1'b1;
                                end else begin
                                    fifo_wr_en <= 1'b1;
                                    fifo_data  <= 32'(audio_in);
                                end
`endif
                            end
                        end
                        if (p2) begin
                            audio_out <= mixed;
                            out_valid <= 1'b1;
`ifdef ECHO_FEEDBACK_EN
                            if (fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                fifo_wr_en <= 1'b1;
                                fifo_data  <= 32'(mixed);
                            end
`endif
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_echo_delay_reader.sv
// Directed bench for echo_delay_reader with a behavioural delay FIFO; works with or without ECHO_FEEDBACK_EN.
module tb_echo_delay_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] delay_num = '0;
    logic [5:0]  gain = '0;
    logic        sample_valid = 1'b0;
    logic [15:0] audio_in = '0;
    logic        fifo_wr_en;
    logic [31:0] fifo_data;
    logic        fifo_rd_en;
    logic [31:0] fifo_q = '0;
    logic        fifo_empty;
    logic        fifo_full;
    logic [15:0] audio_out;
    logic        out_valid;
    logic        underrun, overrun, collision;

    logic        force_empty = 1'b0;
    logic        force_full = 1'b0;
    logic        fifo_clr = 1'b0;
    int          preload_n = 0;
    logic [31:0] mem [0:255];
    int          rp = 0, wp = 0;
    int          cyc = 0, rd_pulses = 0, wr_pulses = 0, out_pulses = 0;
    int          n_tests = 0, n_fail = 0;

    localparam logic [15:0] SINE [0:11] = '{16'd0, 16'd49, 16'd90, 16'd117, 16'd127, 16'd117,
                                             16'd90, 16'd49, 16'd0, 16'hFFCF, 16'hFFA6, 16'hFF8B};
`ifdef ECHO_FEEDBACK_EN
    localparam logic [15:0] ECHO_EXP [0:3] = '{16'd1000, 16'd500, 16'd250, 16'd125};
`else
    localparam logic [15:0] ECHO_EXP [0:3] = '{16'd1000, 16'd500, 16'd0, 16'd0};
`endif

    echo_delay_reader #(.DW(16), .CW(12)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .delay_num(delay_num), .gain(gain),
        .sample_valid(sample_valid), .audio_in(audio_in),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
        .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .audio_out(audio_out), .out_valid(out_valid),
        .underrun(underrun), .overrun(overrun), .collision(collision)
    );

    always #5 clk = ~clk;

    assign fifo_empty = force_empty || (wp == rp);
    assign fifo_full  = force_full || ((wp - rp) >= 256);

    // Behavioural FIFO: read data appears the cycle after fifo_rd_en.
    always @(posedge clk) begin
        if (fifo_clr) begin
            rp <= 0;
            wp <= preload_n;
            for (int k = 0; k < 8; k++) mem[k] <= 32'(k + 1);
        end else begin
            if (fifo_rd_en && (wp != rp)) begin
                fifo_q <= mem[rp % 256];
                rp <= rp + 1;
            end
            if (fifo_wr_en && ((wp - rp) < 256)) begin
                mem[wp % 256] <= fifo_data;
                wp <= wp + 1;
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en === 1'b1) rd_pulses <= rd_pulses + 1;
        if (fifo_wr_en === 1'b1) wr_pulses <= wr_pulses + 1;
        if (out_valid === 1'b1) out_pulses <= out_pulses + 1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Presents one sample in cycle t; returns at the negedge of t+1 with inputs scrambled.
    task automatic send(input logic [15:0] v, input logic [5:0] g, output int t);
        @(negedge clk);
        audio_in = v;
        gain = g;
        sample_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
        audio_in = 16'h5a5a;
        gain = 6'd17;
    endtask

    task automatic do_reset(input int n_pre, input logic [11:0] dly);
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1;
        delay_num = dly;
        sample_valid = 1'b0;
        force_empty = 1'b0;
        force_full = 1'b0;
        preload_n = n_pre;
        fifo_clr = 1'b1;
        step(3);
        fifo_clr = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_flush_preload();
        int t, rd0, wr0;
        do_reset(5, 12'd0);
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        step(1);
        n_tests++;
        if ({fifo_rd_en, fifo_wr_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL first_cycle_strobes: rd/wr=%b expected 00", {fifo_rd_en, fifo_wr_en});
        end
        step(11);
        n_tests++;
        if (rd_pulses - rd0 !== 5) begin
            n_fail++;
            $display("FAIL flush_reads: got %0d expected 5", rd_pulses - rd0);
        end
        n_tests++;
        if (wr_pulses - wr0 !== 0) begin
            n_fail++;
            $display("FAIL flush_writes: got %0d expected 0", wr_pulses - wr0);
        end
        send(16'd100, 6'd0, t);
        n_tests++;
        if ({out_valid, audio_out} !== {1'b1, 16'd100}) begin
            n_fail++;
            $display("FAIL fill_dry_out: valid=%b out=%0d expected 1/100", out_valid, audio_out);
        end
        n_tests++;
        if ({fifo_wr_en, fifo_data} !== {1'b1, 32'd100}) begin
            n_fail++;
            $display("FAIL fill_write: wr=%b data=%h expected 1/00000064", fifo_wr_en, fifo_data);
        end
        step(2);
        send(16'd10, 6'd32, t);
        n_tests++;
        if ({fifo_rd_en, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL run_t1: rd/out_valid=%b expected 10", {fifo_rd_en, out_valid});
        end
`ifndef ECHO_FEEDBACK_EN
        n_tests++;
        if ({fifo_wr_en, fifo_data} !== {1'b1, 32'd10}) begin
            n_fail++;
            $display("FAIL run_ff_write: wr=%b data=%h expected 1/0000000a", fifo_wr_en, fifo_data);
        end
`endif
        step(1);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_t2_valid: got %b expected 0", out_valid);
        end
        step(1);
        n_tests++;
        if ({out_valid, audio_out} !== {1'b1, 16'd60}) begin
            n_fail++;
            $display("FAIL run_mix: valid=%b out=%0d expected 1/60", out_valid, audio_out);
        end
    endtask

    task automatic test_gain_zero();
        int t;
        for (int i = 0; i < 12; i++) begin
            send(SINE[i], 6'd0, t);
            step(1);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL gain0_early[%0d]: valid=%b expected 0", i, out_valid);
            end
            step(1);
            n_tests++;
            if ({out_valid, audio_out} !== {1'b1, SINE[i]}) begin
                n_fail++;
                $display("FAIL gain0_out[%0d]: valid=%b out=%h expected 1/%h", i, out_valid, audio_out, SINE[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int t;
        logic [15:0] live [0:4];
        logic [5:0]  g [0:4];
        logic [15:0] exp_v [0:4];
        live  = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'd100};
        g     = '{6'd0, 6'd63, 6'd0, 6'd63, 6'd63};
        exp_v = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8264};
        for (int i = 0; i < 5; i++) begin
            send(live[i], g[i], t);
            step(2);
            n_tests++;
            if ({out_valid, audio_out} !== {1'b1, exp_v[i]}) begin
                n_fail++;
                $display("FAIL sat[%0d]: valid=%b out=%h expected 1/%h", i, out_valid, audio_out, exp_v[i]);
            end
        end
    endtask

    task automatic test_underrun_collision();
        int t, o0, r0;
        @(negedge clk);
        force_empty = 1'b1;
        send(16'd7, 6'd32, t);
        n_tests++;
        if ({fifo_rd_en, underrun} !== 2'b01) begin
            n_fail++;
            $display("FAIL underrun_flag: rd/underrun=%b expected 01", {fifo_rd_en, underrun});
        end
        step(2);
        n_tests++;
        if ({out_valid, audio_out} !== {1'b1, 16'd7}) begin
            n_fail++;
            $display("FAIL underrun_out: valid=%b out=%0d expected 1/7", out_valid, audio_out);
        end
        force_empty = 1'b0;
        send(16'd40, 6'd0, t);
        n_tests++;
        if (collision !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_early: got %b expected 0", collision);
        end
        step(1);
        sample_valid = 1'b1;
        audio_in = 16'd99;
        step(1);
        sample_valid = 1'b0;
        n_tests++;
        if ({out_valid, audio_out, collision} !== {1'b1, 16'd40, 1'b1}) begin
            n_fail++;
            $display("FAIL collision_first: valid=%b out=%0d coll=%b expected 1/40/1", out_valid, audio_out, collision);
        end
        step(1);
        o0 = out_pulses;
        r0 = rd_pulses;
        step(4);
        n_tests++;
        if ({out_pulses - o0, rd_pulses - r0} !== {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL collision_drop: extra out=%0d rd=%0d expected 0/0", out_pulses - o0, rd_pulses - r0);
        end
    endtask

    task automatic test_overrun();
        int t, w0;
        @(negedge clk);
        force_full = 1'b1;
        w0 = wr_pulses;
        send(16'd3, 6'd0, t);
        step(2);
        n_tests++;
        if ({out_valid, audio_out, overrun} !== {1'b1, 16'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_flag: valid=%b out=%0d ovr=%b expected 1/3/1", out_valid, audio_out, overrun);
        end
        step(1);
        n_tests++;
        if (wr_pulses - w0 !== 0) begin
            n_fail++;
            $display("FAIL overrun_write: got %0d writes expected 0", wr_pulses - w0);
        end
        force_full = 1'b0;
    endtask

    task automatic test_abort();
        int t, o0, r0, w0;
        send(16'd11, 6'd0, t);
        en = 1'b0;
        step(1);
        o0 = out_pulses;
        r0 = rd_pulses;
        w0 = wr_pulses;
        step(6);
        n_tests++;
        if ({out_pulses - o0, rd_pulses - r0, wr_pulses - w0} !== 96'd0) begin
            n_fail++;
            $display("FAIL abort_strobes: out=%0d rd=%0d wr=%0d expected 0/0/0",
                     out_pulses - o0, rd_pulses - r0, wr_pulses - w0);
        end
        n_tests++;
        if ({underrun, overrun, collision} !== 3'b111) begin
            n_fail++;
            $display("FAIL flags_sticky_idle: got %b expected 111", {underrun, overrun, collision});
        end
        en = 1'b1;
        step(1);
        n_tests++;
        if ({underrun, overrun, collision} !== 3'b000) begin
            n_fail++;
            $display("FAIL flags_clear_on_enable: got %b expected 000", {underrun, overrun, collision});
        end
    endtask

    task automatic test_reset();
        int t;
        step(12);
        force_full = 1'b1;
        send(16'd77, 6'd0, t);
        n_tests++;
        if ({out_valid, audio_out, fifo_wr_en, overrun} !== {1'b1, 16'd77, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fill_full: valid=%b out=%0d wr=%b ovr=%b expected 1/77/0/1",
                     out_valid, audio_out, fifo_wr_en, overrun);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({audio_out, fifo_data} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset_data: out=%h fifo_data=%h expected 0/0", audio_out, fifo_data);
        end
        n_tests++;
        if ({fifo_wr_en, fifo_rd_en, out_valid, underrun, overrun, collision} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {fifo_wr_en, fifo_rd_en, out_valid, underrun, overrun, collision});
        end
        force_full = 1'b0;
    endtask

    task automatic test_fill_run();
        int t;
        do_reset(0, 12'd127);
        step(4);
        for (int i = 0; i < 127; i++) begin
            send(16'(1000 + i), 6'd32, t);
            n_tests++;
            if ({out_valid, audio_out, fifo_wr_en, fifo_data} !== {1'b1, 16'(1000 + i), 1'b1, 32'(1000 + i)}) begin
                n_fail++;
                $display("FAIL fill127[%0d]: valid=%b out=%0d wr=%b data=%0d expected 1/%0d/1/%0d",
                         i, out_valid, audio_out, fifo_wr_en, fifo_data, 1000 + i, 1000 + i);
            end
            step(2);
        end
        send(16'd5, 6'd32, t);
        n_tests++;
        if ({fifo_rd_en, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL run127_t1: rd/out_valid=%b expected 10", {fifo_rd_en, out_valid});
        end
        step(2);
        n_tests++;
        if ({out_valid, audio_out} !== {1'b1, 16'd505}) begin
            n_fail++;
            $display("FAIL run127_first: valid=%b out=%0d expected 1/505", out_valid, audio_out);
        end
        send(16'd0, 6'd32, t);
        step(2);
        n_tests++;
        if ({out_valid, audio_out} !== {1'b1, 16'd500}) begin
            n_fail++;
            $display("FAIL run127_second: valid=%b out=%0d expected 1/500", out_valid, audio_out);
        end
    endtask

    task automatic test_echo_impulse();
        int t;
        logic [15:0] got [0:12];
        do_reset(0, 12'd4);
        step(4);
        for (int i = 0; i < 13; i++) begin
            send((i == 0) ? 16'd1000 : 16'd0, 6'd32, t);
            if (i >= 4) step(2);
            n_tests++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL echo_valid[%0d]: got %b expected 1", i, out_valid);
            end
            got[i] = audio_out;
            if (i < 4) step(2);
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (got[4 * k] !== ECHO_EXP[k]) begin
                n_fail++;
                $display("FAIL echo_tap[%0d]: got %0d expected %0d", k, got[4 * k], ECHO_EXP[k]);
            end
        end
        n_tests++;
        if (got[5] !== 16'd0) begin
            n_fail++;
            $display("FAIL echo_gap: got %0d expected 0", got[5]);
        end
    endtask

    initial begin
        test_flush_preload();
        test_gain_zero();
        test_saturation();
        test_underrun_collision();
        test_overrun();
        test_abort();
        test_reset();
        test_fill_run();
        test_echo_impulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
